// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: opcodes, states,
// ALU/write-back selects and trap causes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_IARITH) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_wait_timer.sv
// Wait-state counter for memory handshakes; flags the last permitted cycle
// of a FETCH or MEM wait that still has no ready.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturates at LAST so a disabled timeout never wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && !ready && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = active && !ready && (cnt == LAST);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// wait states, sticky HALT/TRAP and a retired-instruction counter.
module riscv_multicycle_ctrl #(
  parameter int OPCODE_W       = 7,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_EN     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                branch,
  output logic                jump,
  output logic                jalr,
  output logic                halted,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic                instr_retired,
  output logic [CNT_W-1:0]    retired_count
);

  import riscv_ctrl_pkg::*;

  state_t     state, state_nxt;
  logic [6:0] op_cur, op_q;
  logic       is_rtype, is_load, is_iarith, is_store, is_branch, is_jal, is_jalr;
  logic       wait_active, wait_ready, wait_clear, wait_expired, timeout;

  assign op_cur    = 7'(opcode);
  assign is_rtype  = (op_q == OP_RTYPE);
  assign is_load   = (op_q == OP_LOAD);
  assign is_iarith = (op_q == OP_IARITH);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);

  assign wait_active = (state == S_FETCH) || (state == S_MEM);
  assign wait_ready  = (state == S_FETCH) ? imem_ready : dmem_ready;
  assign wait_clear  = (state_nxt != state);
  assign timeout     = (TIMEOUT_EN != 0) && wait_expired;

  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .active (wait_active),
    .ready  (wait_ready),
    .clear  (wait_clear),
    .expired(wait_expired)
  );

  // Ready in the final wait cycle is checked first, so it beats the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
        if (imem_ready)   state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_DECODE: begin
        if (op_cur == OP_HALT)         state_nxt = S_HALT;
        else if (!is_known_op(op_cur)) state_nxt = S_TRAP;
        else                           state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_branch)               state_nxt = S_FETCH;
        else if (is_load || is_store) state_nxt = S_MEM;
        else                         state_nxt = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)   state_nxt = is_load ? S_WB : S_FETCH;
        else if (timeout) state_nxt = S_TRAP;
      end
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      op_q          <= '0;
      trap_cause    <= CAUSE_NONE;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= op_cur;
      if ((state_nxt == S_TRAP) && (state != S_TRAP))
        trap_cause <= (state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (instr_retired) retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Outputs are forced low while reset is held so requests drop at once.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;
    branch        = 1'b0;
    jump          = 1'b0;
    jalr          = 1'b0;
    halted        = 1'b0;
    trap          = 1'b0;
    instr_retired = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        S_EXEC: begin
          alu_src = is_load || is_store || is_iarith || is_jalr;
          if (is_rtype || is_iarith) alu_op = ALU_FUNCT;
          else if (is_branch)        alu_op = ALU_BRANCH;
          branch        = is_branch;
          pc_write      = is_branch;
          instr_retired = is_branch;
        end
        S_MEM: begin
          dmem_req      = 1'b1;
          mem_read      = is_load;
          mem_write     = is_store;
          pc_write      = is_store && dmem_ready;
          instr_retired = is_store && dmem_ready;
        end
        S_WB: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          if (is_load)               wb_sel = WB_MEM;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          jump = is_jal;
          jalr = is_jalr;
        end
        S_HALT:  halted = 1'b1;
        S_TRAP:  trap   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed-vector bench for riscv_multicycle_ctrl (CNT_W=4, TIMEOUT_CYCLES=8).
module tb_riscv_multicycle_ctrl;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;
  localparam logic [6:0] OP_HT = 7'b1111111;

  // ctl = {imem_req,dmem_req,ir_write,pc_write,alu_src,alu_op,mem_read,
  //        mem_write,reg_write,wb_sel,branch,jump,jalr}
  localparam logic [14:0] C_IMEM   = 15'h4000;
  localparam logic [14:0] C_DMEM   = 15'h2000;
  localparam logic [14:0] C_IRW    = 15'h1000;
  localparam logic [14:0] C_PCW    = 15'h0800;
  localparam logic [14:0] C_ASRC   = 15'h0400;
  localparam logic [14:0] C_AOP_FN = 15'h0200;
  localparam logic [14:0] C_AOP_BR = 15'h0100;
  localparam logic [14:0] C_MRD    = 15'h0080;
  localparam logic [14:0] C_MWR    = 15'h0040;
  localparam logic [14:0] C_RW     = 15'h0020;
  localparam logic [14:0] C_WB_PC4 = 15'h0010;
  localparam logic [14:0] C_WB_MEM = 15'h0008;
  localparam logic [14:0] C_BR     = 15'h0004;
  localparam logic [14:0] C_JMP    = 15'h0002;
  localparam logic [14:0] C_JALR   = 15'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, ir_write, pc_write, alu_src, mem_read, mem_write;
  logic       reg_write, branch, jump, jalr, halted, trap, instr_retired;
  logic [1:0] alu_op, wb_sel, trap_cause;
  logic [3:0] retired_count;
  logic [14:0] ctl;
  logic [2:0]  aux;  // {instr_retired, halted, trap}

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ctl = {imem_req, dmem_req, ir_write, pc_write, alu_src, alu_op, mem_read,
                mem_write, reg_write, wb_sel, branch, jump, jalr};
  assign aux = {instr_retired, halted, trap};

  riscv_multicycle_ctrl #(
    .OPCODE_W(7), .CNT_W(4), .TIMEOUT_EN(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .branch(branch), .jump(jump), .jalr(jalr),
    .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .instr_retired(instr_retired), .retired_count(retired_count)
  );

  task automatic drive(input logic ir, input logic dr);
    imem_ready = ir;
    dmem_ready = dr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Leaves the FSM at the start of EXEC for the given opcode.
  task automatic fetch_decode(input logic [6:0] op);
    opcode = op;
    drive(1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0);
    next_cycle();
  endtask

  task automatic retire_branch();
    fetch_decode(OP_BR);
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #2;
    tests++; if (ctl !== 15'h0) begin fails++; $display("FAIL reset_ctl: got %h expected %h", ctl, 15'h0); end
    tests++; if (aux !== 3'b000) begin fails++; $display("FAIL reset_aux: got %b expected 000", aux); end
    tests++; if (retired_count !== 4'd0 || trap_cause !== 2'b00) begin
      fails++; $display("FAIL reset_cnt_cause: got %0d/%b expected 0/00", retired_count, trap_cause);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0);
    tests++; if (ctl !== C_IMEM) begin fails++; $display("FAIL reset_release_fetch: got %h expected %h", ctl, C_IMEM); end
  endtask

  task automatic test_rtype();
    do_reset();
    opcode = OP_R;
    drive(1'b1, 1'b0);
    tests++; if (ctl !== (C_IMEM | C_IRW)) begin fails++; $display("FAIL rtype_fetch: got %h expected %h", ctl, C_IMEM | C_IRW); end
    next_cycle();
    drive(1'b0, 1'b0);
    tests++; if (ctl !== 15'h0) begin fails++; $display("FAIL rtype_decode: got %h expected 0000", ctl); end
    next_cycle();
    opcode = OP_HT;  // EXEC must use the opcode latched in DECODE
    #1;
    tests++; if (ctl !== C_AOP_FN) begin fails++; $display("FAIL rtype_exec: got %h expected %h", ctl, C_AOP_FN); end
    next_cycle();
    tests++; if (ctl !== (C_PCW | C_RW)) begin fails++; $display("FAIL rtype_wb: got %h expected %h", ctl, C_PCW | C_RW); end
    tests++; if (aux !== 3'b100) begin fails++; $display("FAIL rtype_retire_pulse: got %b expected 100", aux); end
    next_cycle();
    tests++; if (ctl !== C_IMEM || retired_count !== 4'd1 || aux !== 3'b000) begin
      fails++; $display("FAIL rtype_after: ctl %h cnt %0d aux %b expected %h 1 000", ctl, retired_count, aux, C_IMEM);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    fetch_decode(OP_LD);
    tests++; if (ctl !== C_ASRC) begin fails++; $display("FAIL load_exec: got %h expected %h", ctl, C_ASRC); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 2);
      tests++; if (ctl !== (C_DMEM | C_MRD) || aux !== 3'b000) begin
        fails++; $display("FAIL load_mem_%0d: got %h/%b expected %h/000", k, ctl, aux, C_DMEM | C_MRD);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0);
    tests++; if (ctl !== (C_PCW | C_RW | C_WB_MEM)) begin
      fails++; $display("FAIL load_wb: got %h expected %h", ctl, C_PCW | C_RW | C_WB_MEM);
    end
    next_cycle();
    fetch_decode(OP_ST);
    tests++; if (ctl !== C_ASRC) begin fails++; $display("FAIL store_exec: got %h expected %h", ctl, C_ASRC); end
    next_cycle();
    drive(1'b0, 1'b1);
    tests++; if (ctl !== (C_DMEM | C_MWR | C_PCW) || aux !== 3'b100) begin
      fails++; $display("FAIL store_mem: got %h/%b expected %h/100", ctl, aux, C_DMEM | C_MWR | C_PCW);
    end
    next_cycle();
    drive(1'b0, 1'b0);
    tests++; if (ctl !== C_IMEM || retired_count !== 4'd2) begin
      fails++; $display("FAIL store_after: ctl %h cnt %0d expected %h 2", ctl, retired_count, C_IMEM);
    end
  endtask

  task automatic test_jal_jalr();
    do_reset();
    fetch_decode(OP_JL);
    tests++; if (ctl !== 15'h0) begin fails++; $display("FAIL jal_exec: got %h expected 0000", ctl); end
    next_cycle();
    tests++; if (ctl !== (C_PCW | C_RW | C_WB_PC4 | C_JMP)) begin
      fails++; $display("FAIL jal_wb: got %h expected %h", ctl, C_PCW | C_RW | C_WB_PC4 | C_JMP);
    end
    next_cycle();
    fetch_decode(OP_JR);
    tests++; if (ctl !== C_ASRC) begin fails++; $display("FAIL jalr_exec: got %h expected %h", ctl, C_ASRC); end
    next_cycle();
    tests++; if (ctl !== (C_PCW | C_RW | C_WB_PC4 | C_JALR)) begin
      fails++; $display("FAIL jalr_wb: got %h expected %h", ctl, C_PCW | C_RW | C_WB_PC4 | C_JALR);
    end
    next_cycle();
    tests++; if (retired_count !== 4'd2) begin fails++; $display("FAIL jal_jalr_count: got %0d expected 2", retired_count); end
  endtask

  task automatic test_branch();
    do_reset();
    fetch_decode(OP_BR);
    tests++; if (ctl !== (C_PCW | C_BR | C_AOP_BR) || aux !== 3'b100) begin
      fails++; $display("FAIL branch_exec: got %h/%b expected %h/100", ctl, aux, C_PCW | C_BR | C_AOP_BR);
    end
    next_cycle();
    tests++; if (ctl !== C_IMEM || retired_count !== 4'd1) begin
      fails++; $display("FAIL branch_after: ctl %h cnt %0d expected %h 1", ctl, retired_count, C_IMEM);
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    retire_branch();
    fetch_decode(7'b0000000);
    tests++; if (aux !== 3'b001 || trap_cause !== 2'b01 || ctl !== 15'h0) begin
      fails++; $display("FAIL illegal_trap: aux %b cause %b ctl %h expected 001 01 0000", aux, trap_cause, ctl);
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1);
      tests++; if (ctl !== 15'h0 || aux !== 3'b001 || trap_cause !== 2'b01 || retired_count !== 4'd1) begin
        fails++; $display("FAIL illegal_frozen_%0d: ctl %h aux %b cause %b cnt %0d", c, ctl, aux, trap_cause, retired_count);
      end
      next_cycle();
    end
    do_reset();
    fetch_decode(OP_HT);
    tests++; if (aux !== 3'b010 || trap_cause !== 2'b00 || ctl !== 15'h0) begin
      fails++; $display("FAIL halt_enter: aux %b cause %b ctl %h expected 010 00 0000", aux, trap_cause, ctl);
    end
    for (int c = 0; c < 5; c++) begin
      opcode = OP_R;
      drive(1'b1, 1'b1);
      tests++; if (aux !== 3'b010 || ctl !== 15'h0) begin
        fails++; $display("FAIL halt_sticky_%0d: aux %b ctl %h expected 010 0000", c, aux, ctl);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 1'b0);
      tests++; if (ctl !== C_IMEM || aux !== 3'b000) begin
        fails++; $display("FAIL fetch_wait_%0d: ctl %h aux %b expected %h 000", c, ctl, aux, C_IMEM);
      end
      next_cycle();
    end
    tests++; if (aux !== 3'b001 || trap_cause !== 2'b10 || ctl !== 15'h0) begin
      fails++; $display("FAIL fetch_timeout: aux %b cause %b ctl %h expected 001 10 0000", aux, trap_cause, ctl);
    end
    do_reset();
    opcode = OP_R;
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b1, 1'b0);
    tests++; if (ctl !== (C_IMEM | C_IRW)) begin fails++; $display("FAIL fetch_last_ready: got %h expected %h", ctl, C_IMEM | C_IRW); end
    next_cycle();
    drive(1'b0, 1'b0);
    tests++; if (ctl !== 15'h0 || aux !== 3'b000) begin
      fails++; $display("FAIL fetch_ready_wins: ctl %h aux %b expected 0000 000", ctl, aux);
    end
    next_cycle();
    tests++; if (ctl !== C_AOP_FN) begin fails++; $display("FAIL fetch_ready_exec: got %h expected %h", ctl, C_AOP_FN); end
    do_reset();
    fetch_decode(OP_ST);
    next_cycle();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 1'b0);
      next_cycle();
    end
    tests++; if (aux !== 3'b001 || trap_cause !== 2'b10 || retired_count !== 4'd0) begin
      fails++; $display("FAIL mem_timeout: aux %b cause %b cnt %0d expected 001 10 0", aux, trap_cause, retired_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    retire_branch();
    fetch_decode(OP_LD);
    next_cycle();
    drive(1'b0, 1'b0);
    tests++; if (ctl !== (C_DMEM | C_MRD) || retired_count !== 4'd1) begin
      fails++; $display("FAIL midmem_before: ctl %h cnt %0d expected %h 1", ctl, retired_count, C_DMEM | C_MRD);
    end
    reset = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b0 || ctl !== 15'h0 || retired_count !== 4'd0) begin
      fails++; $display("FAIL midmem_reset: dmem_req %b ctl %h cnt %0d expected 0 0000 0", dmem_req, ctl, retired_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0);
    tests++; if (ctl !== C_IMEM) begin fails++; $display("FAIL midmem_release: got %h expected %h", ctl, C_IMEM); end
    next_cycle();
    tests++; if (ctl !== C_IMEM) begin fails++; $display("FAIL midmem_first_edge: got %h expected %h", ctl, C_IMEM); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) retire_branch();
    tests++; if (retired_count !== 4'd15) begin fails++; $display("FAIL wrap_15: got %0d expected 15", retired_count); end
    retire_branch();
    tests++; if (retired_count !== 4'd0) begin fails++; $display("FAIL wrap_16: got %0d expected 0", retired_count); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_jal_jalr();
    test_branch();
    test_illegal_halt();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RISC-V datapath. It is the sequential successor to the single-cycle opcode decoder: it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memories that may insert wait states. It also provides a sticky HALT, an illegal-opcode/timeout TRAP, and an instruction-retired counter. It sits between the IR/opcode register and the datapath control inputs.

Parameters:
OPCODE_W, 7, opcode field width
CNT_W, 32, width of retired-instruction counter (wraps)
TIMEOUT_EN, 1, enables memory wait timeout
TIMEOUT_CYCLES, 16, max cycles in FETCH/MEM without ready (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
opcode  in  OPCODE_W  IR[6:0]; valid from DECODE onward
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
ir_write  out  1  load IR (one-cycle pulse)
pc_write  out  1  update PC (one-cycle pulse)
alu_src  out  1  ALU B = immediate
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
mem_read  out  1  load access (qualifies dmem_req)
mem_write  out  1  store access (qualifies dmem_req)
reg_write  out  1  register file write
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
branch  out  1  PC mux: conditional branch target
jump  out  1  PC mux: JAL target
jalr  out  1  PC mux: JALR target
halted  out  1  sticky HALT indication
trap  out  1  sticky TRAP indication
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
instr_retired  out  1  one-cycle pulse per completed instruction
retired_count  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, active-high): state=FETCH, all outputs 0, retired_count=0, trap_cause=00, wait counter=0. Reset mid-access drops imem_req/dmem_req immediately.
- Moore outputs are decoded from state and opcode latched at DECODE. imem_req, dmem_req, ir_write and the EXEC-state alu_op are the exceptions defined below.
- FETCH: imem_req=1. When imem_ready=1, ir_write=1 that cycle, then go to DECODE. Minimum 1 cycle.
- DECODE (1 cycle): latch opcode.
  - 1111111 -> HALT.
  - Unknown opcode -> TRAP, cause 01.
  - Else -> EXEC.
  - Recognised opcodes: 0110011, 0000011, 0010011, 0100011, 1100011, 1101111, 1100111.
- EXEC (1 cycle): alu_src=1 for load/store/I-arith/JALR. alu_op=10 for R/I-arith, 01 for branch, 00 otherwise.
  - Branch: branch=1, pc_write=1, instr_retired=1, then FETCH. The datapath selects the target or PC+4.
  - Load/store -> MEM.
  - Other types -> WB.
- MEM: dmem_req=1, with mem_read=1 (load) or mem_write=1 (store), held until dmem_ready.
  - On ready, load -> WB.
  - On ready, store: pc_write=1, instr_retired=1, then FETCH.
- WB (1 cycle): reg_write=1, pc_write=1, instr_retired=1, then FETCH.
  - wb_sel=01 for load, 10 for JAL/JALR, else 00.
  - jump=1 for JAL, jalr=1 for JALR.
- Wait counter: clears on entering FETCH/MEM and increments each cycle while ready=0.
  - If TIMEOUT_EN and the counter reaches TIMEOUT_CYCLES-1 with ready still 0, go to TRAP with cause 10. The state occupies exactly TIMEOUT_CYCLES cycles.
  - Ready in that final cycle wins over timeout.
- HALT/TRAP: absorbing until reset. All control outputs are 0 and halted/trap are held at 1. Memory ready inputs are ignored.
- retired_count increments on every instr_retired and wraps modulo 2^CNT_W without a flag.
- Cycle latency with zero wait states:
  - R, I-arith, JAL, JALR: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Invariants: at most one of pc_write, ir_write per cycle. mem_read and mem_write are never both 1.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - opcode constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP)
  - alu_op, wb_sel and trap_cause encodings
- Sub-module ctrl_wait_timer: owns the wait counter and timeout compare, parametrised by TIMEOUT_CYCLES. Inputs are active, ready and clear; the output is expired.

Test Plan:
- R-type 0110011, imem_ready=1 every cycle -> ir_write in cycle 1, reg_write=1 and wb_sel=00 in cycle 4, instr_retired pulse, retired_count=1.
- Load 0000011, dmem_ready low for 2 MEM cycles -> dmem_req=1 and mem_read=1 for 3 cycles, WB in cycle 7 with wb_sel=01; a store then retires in MEM with reg_write never 1.
- JAL 1101111 then JALR 1100111 -> WB with wb_sel=10, jump=1 then jalr=1, pc_write=1; JALR has alu_src=1 in EXEC; retired_count=2.
- Opcode 0000000 -> TRAP one cycle after DECODE, trap=1, trap_cause=01, outputs stay frozen 20 cycles, retired_count unchanged; HALT 1111111 -> halted=1 sticky.
- TIMEOUT_CYCLES=8, imem_ready stuck 0 -> FETCH lasts exactly 8 cycles, then trap_cause=10; repeat with ready in cycle 8 -> normal DECODE.
- Assert reset during MEM with dmem_req=1 -> dmem_req=0 immediately, retired_count=0; after release, FETCH with imem_req=1 on the first edge. CNT_W=4 with 16 retires -> count wraps to 0.
